// File: rtl/inst_fetch_buf.sv
// Instruction-fetch front end: fetch PC, DEPTH-entry (pc, inst) prefetch FIFO and a
// registered ID-stage output. The ROM keeps streaming while ID stalls; redirects keep the delay slot.
module inst_fetch_buf #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      rom_ce_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_data_i,
    input  logic                      stall_i,
    input  logic                      branch_flag_i,
    input  logic [ADDR_W-1:0]         branch_target_address_i,
    output logic [ADDR_W-1:0]         id_pc_o,
    output logic [DATA_W-1:0]         id_inst_o,
    output logic                      id_valid_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              ce_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [DATA_W-1:0] id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;

    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
    logic [DATA_W-1:0] mem_inst_q [DEPTH];

    logic empty, full, acc, br, rom_ce, bypass, pop, push;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign acc    = !stall_i;
    assign br     = branch_flag_i && acc;
    // A full FIFO can still take a fetch when ID drains one entry in the same cycle.
    assign rom_ce = ce_q && (!full || acc);
    assign bypass = acc && empty && rom_ce;
    assign pop    = acc && !empty;
    assign push   = rom_ce && !bypass;

    always_comb begin
        fpc_d      = fpc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;

        if (br) begin
            // Delay slot is the oldest instruction not yet issued; everything younger is dropped.
            if (!empty) begin
                id_pc_d    = mem_pc_q[rd_ptr_q];
                id_inst_d  = mem_inst_q[rd_ptr_q];
                id_valid_d = 1'b1;
            end else if (rom_ce) begin
                id_pc_d    = fpc_q;
                id_inst_d  = rom_data_i;
                id_valid_d = 1'b1;
            end else begin
                id_pc_d    = '0;
                id_inst_d  = '0;
                id_valid_d = 1'b0;
            end
            fpc_d    = branch_target_address_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                id_pc_d    = mem_pc_q[rd_ptr_q];
                id_inst_d  = mem_inst_q[rd_ptr_q];
                id_valid_d = 1'b1;
            end else if (bypass) begin
                id_pc_d    = fpc_q;
                id_inst_d  = rom_data_i;
                id_valid_d = 1'b1;
            end else if (acc) begin
                id_pc_d    = '0;
                id_inst_d  = '0;
                id_valid_d = 1'b0;
            end
            if (rom_ce)
                fpc_d = fpc_q + ADDR_W'(4);
            if (push)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q      <= RESET_PC;
            ce_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            ce_q       <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !br) begin
            mem_pc_q[wr_ptr_q]   <= fpc_q;
            mem_inst_q[wr_ptr_q] <= rom_data_i;
        end
    end

    assign rom_ce_o   = rom_ce;
    assign rom_addr_o = fpc_q;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;
    assign count_o    = count_q;
endmodule
